// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_PARITY_EN to build the parity bit (PARITY_ODD selects sense).
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
      DATA_BITS < 5 || DATA_BITS > 8 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx_ctrl: illegal parameter");
  end

  localparam logic [15:0] CNT_MAX   = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign tick = (cnt_q == CNT_MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (tx_valid_i) begin
          state_d = START;
          shift_d = tx_data_i;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data_i) ^ PARITY_ODD[0];
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 4'd1;
          if (bit_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            bit_d   = '0;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q == LAST_STOP) begin
            state_d = IDLE;
            bit_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops.
  always_comb begin
    tx_d    = 1'b1;
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    done_d  = (state_q == STOP) && (state_d == IDLE);
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_o       = tx_q;
  assign busy_o     = busy_q;
  assign tx_ready_o = ready_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-level model compared every cycle,
// plus literal bit patterns for the directed cases.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int CA = 4;
  localparam int SA = 1;
  localparam int CB = 3;
  localparam int SB = 2;
  localparam int FA = (9 + P + SA) * CA;
  localparam int FB = (9 + P + SB) * CB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] a_data = '0;
  logic [7:0] b_data = '0;
  logic       a_valid = 1'b0;
  logic       b_valid = 1'b0;
  logic       a_tx, a_ready, a_busy, a_done;
  logic       b_tx, b_ready, b_busy, b_done;

  int total = 0;
  int bad = 0;

  logic tr_tx [0:255];
  logic tr_done [0:255];
  logic tr_ready [0:255];

  bit         a_act = 1'b0;
  int         a_k = 0;
  logic [7:0] a_b = '0;
  bit         b_act = 1'b0;
  int         b_k = 0;
  logic [7:0] b_b = '0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .CLKS_PER_BIT(CA), .DATA_BITS(8), .STOP_BITS(SA), .PARITY_ODD(0)
  ) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .tx_data_i(a_data), .tx_valid_i(a_valid),
    .tx_ready_o(a_ready), .tx_o(a_tx),
    .busy_o(a_busy), .done_o(a_done)
  );

  uart_tx_ctrl #(
    .CLKS_PER_BIT(CB), .DATA_BITS(8), .STOP_BITS(SB), .PARITY_ODD(1)
  ) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .tx_data_i(b_data), .tx_valid_i(b_valid),
    .tx_ready_o(b_ready), .tx_o(b_tx),
    .busy_o(b_busy), .done_o(b_done)
  );

  // Expected {tx,busy,ready,done} in cycle k after acceptance.
  function automatic logic [3:0] model_out(
    input bit act, input int k, input logic [7:0] b,
    input int cpb, input int sb, input bit odd);
    int f;
    int m;
    logic bt;
    f = (9 + P + sb) * cpb;
    if (!act) return 4'b1010;
    if (k > f) return 4'b1011;
    m = (k - 1) / cpb;
    if (m == 0) bt = 1'b0;
    else if (m <= 8) bt = b[m-1];
    else if (P == 1 && m == 9) bt = (^b) ^ odd;
    else bt = 1'b1;
    return {bt, 3'b100};
  endfunction

  task automatic step(inout bit act, inout int k,
                      inout logic [7:0] b, input logic v,
                      input logic [7:0] d, input int f);
    if ((!act || k == f + 1) && v) begin
      act = 1'b1;
      k = 1;
      b = d;
    end else if (act) begin
      if (k == f + 1) act = 1'b0;
      else k = k + 1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      a_act = 1'b0;
      b_act = 1'b0;
    end else begin
      step(a_act, a_k, a_b, a_valid, a_data, FA);
      step(b_act, b_k, b_b, b_valid, b_data, FB);
    end
  end

  initial forever begin
    logic [3:0] ea;
    logic [3:0] eb;
    @(negedge clk);
    ea = model_out(a_act, a_k, a_b, CA, SA, 1'b0);
    eb = model_out(b_act, b_k, b_b, CB, SB, 1'b1);
    total++;
    if ({a_tx, a_busy, a_ready, a_done} !== ea) begin
      bad++;
      $display("FAIL model_a t=%0t got=%b exp=%b", $time,
               {a_tx, a_busy, a_ready, a_done}, ea);
    end
    total++;
    if ({b_tx, b_busy, b_ready, b_done} !== eb) begin
      bad++;
      $display("FAIL model_b t=%0t got=%b exp=%b", $time,
               {b_tx, b_busy, b_ready, b_done}, eb);
    end
  end

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Frame bit m of a trace starting at base spans base+m*cpb+1 .. base+(m+1)*cpb.
  task automatic check_bits(input string nm, input int base,
                            input int cpb, input int first,
                            input int nb, input logic [15:0] expv);
    for (int m = 0; m < nb; m++) begin
      logic ok;
      int c0;
      ok = 1'b1;
      c0 = base + (first + m) * cpb + 1;
      for (int c = c0; c < c0 + cpb; c++)
        if (tr_tx[c] !== expv[m]) ok = 1'b0;
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s bit%0d got=%b exp=%b", nm, first + m,
                 tr_tx[c0], expv[m]);
      end
    end
  endtask

  task automatic send(input bit sel, input logic [7:0] d,
                      input logic [7:0] d2, input bit b2b,
                      input int n, input bit tog);
    int t;
    t = 0;
    @(negedge clk);
    if (sel) begin b_data = d; b_valid = 1'b1; end
    else begin a_data = d; a_valid = 1'b1; end
    while (((sel ? b_ready : a_ready) !== 1'b1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (t >= 200) begin
      bad++;
      $display("FAIL accept_timeout got=%0d exp=<200", t);
    end
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (b2b) a_data = d2;
        else if (sel) b_valid = 1'b0;
        else a_valid = 1'b0;
      end
      if (b2b && c == FA + 2) a_valid = 1'b0;
      if (tog && c < 38) begin
        a_valid = c[0];
        a_data = 8'(c * 37);
      end
      if (tog && c == 38) a_valid = 1'b0;
      tr_tx[c]    = sel ? b_tx : a_tx;
      tr_done[c]  = sel ? b_done : a_done;
      tr_ready[c] = sel ? b_ready : a_ready;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_a", 16'({a_tx, a_busy, a_ready, a_done}), 16'h000a);
    chk("reset_b", 16'({b_tx, b_busy, b_ready, b_done}), 16'h000a);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send(1'b0, 8'hA5, 8'h00, 1'b0, FA + 2, 1'b0);
    check_bits("a5_frame", 0, CA, 0, 9, 16'h014a);
    check_bits("a5_stop", 0, CA, 9 + P, 1, 16'h0001);
    chk("a5_done_at", 16'({tr_done[FA], tr_done[FA+1]}), 16'h0001);
    chk("a5_ready_idle", 16'(tr_ready[FA+1]), 16'h0001);
`ifdef UART_TX_PARITY_EN
    check_bits("a5_par_even", 0, CA, 9, 1, 16'h0000);
    send(1'b0, 8'hA4, 8'h00, 1'b0, FA + 2, 1'b0);
    check_bits("a4_par_even", 0, CA, 9, 1, 16'h0001);
`endif

    send(1'b1, 8'hA5, 8'h00, 1'b0, FB + 2, 1'b0);
    check_bits("b_frame", 0, CB, 0, 9, 16'h014a);
    check_bits("b_stop2", 0, CB, 9 + P, 2, 16'h0003);
    chk("b_done_at", 16'({tr_done[FB], tr_done[FB+1]}), 16'h0001);
`ifdef UART_TX_PARITY_EN
    check_bits("b_par_odd", 0, CB, 9, 1, 16'h0001);
`endif

    send(1'b0, 8'h00, 8'hFF, 1'b1, 2 * FA + 6, 1'b0);
    check_bits("b2b_00", 0, CA, 0, 9, 16'h0000);
    check_bits("b2b_stop", 0, CA, 9 + P, 1, 16'h0001);
    chk("b2b_gap", 16'({tr_tx[FA+1], tr_tx[FA+2]}), 16'h0002);
    check_bits("b2b_ff", FA + 1, CA, 0, 9, 16'h01fe);
    cnt = 0;
    for (int c = 1; c <= 2 * FA + 6; c++) if (tr_done[c] === 1'b1) cnt++;
    chk("b2b_done_cnt", 16'(cnt), 16'd2);

    send(1'b0, 8'h55, 8'h00, 1'b0, FA + 1, 1'b1);
    check_bits("mid_55", 0, CA, 0, 9, 16'h00aa);
    cnt = 0;
    for (int c = 1; c <= FA; c++) if (tr_ready[c] !== 1'b0) cnt++;
    chk("mid_ready_low", 16'(cnt), 16'd0);
    chk("mid_ready_idle", 16'(tr_ready[FA+1]), 16'h0001);

    send(1'b0, 8'hC3, 8'h00, 1'b0, 18, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid", 16'({a_tx, a_busy, a_ready, a_done}), 16'h000a);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_done !== 1'b0) cnt++;
    end
    rst_n = 1'b1;
    repeat (FA) begin
      @(negedge clk);
      if (a_done !== 1'b0) cnt++;
    end
    chk("rst_no_done", 16'(cnt), 16'd0);

    send(1'b0, 8'h3C, 8'h00, 1'b0, FA + 2, 1'b0);
    check_bits("post_rst_3c", 0, CA, 0, 9, 16'h0078);
    check_bits("post_rst_stop", 0, CA, 9 + P, 1, 16'h0001);
    chk("post_rst_done", 16'({tr_done[FA], tr_done[FA+1]}), 16'h0001);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that sequences one serial frame per accepted byte: start bit, data bits LSB first, optional parity, stop bit(s). It owns the baud-rate divider, the per-frame bit counter and the shift register, and drives the serial line directly. It sits between the byte-producing logic (valid/ready handshake) and the TX pin.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity. Used only when UART_TX_PARITY_EN is defined.

Ports:
- clk_i  input  1  system clock; all logic is on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- tx_data_i  input  DATA_BITS  byte to transmit; sampled on acceptance.
- tx_valid_i  input  1  a byte is offered on tx_data_i.
- tx_ready_o  output  1  controller can accept a byte; high only in IDLE.
- tx_o  output  1  serial line; idle level is 1.
- busy_o  output  1  a frame is in progress (any state other than IDLE).
- done_o  output  1  one-cycle pulse when a frame completes.

## Operation
- States are IDLE, START, DATA, PARITY and STOP.
- IDLE:
  - tx_o=1 and tx_ready_o=1.
  - When tx_valid_i && tx_ready_o, the controller latches tx_data_i into the shift register and goes to START.
- START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx_o=shift[0].
  - Every CLKS_PER_BIT cycles: shift right by one and increment the bit counter.
  - After DATA_BITS bits: go to PARITY if it is compiled in, otherwise go to STOP.
- PARITY:
  - tx_o = XOR of the latched data, XOR PARITY_ODD.
  - Lasts CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx_o=1 for STOP_BITS×CLKS_PER_BIT cycles, then go to IDLE.
  - done_o pulses high for one cycle on the IDLE entry cycle.
- Baud divider:
  - 16-bit counter that counts 0..CLKS_PER_BIT-1.
  - Cleared on every state transition and on acceptance.
  - A bit boundary is the cycle where the counter equals CLKS_PER_BIT-1.
- Bit counter: 4 bits wide, cleared on entry to DATA and STOP. In STOP it counts stop bits.
- tx_data_i and tx_valid_i are ignored outside IDLE. A change to tx_data_i mid-frame has no effect.
- The parity value is computed from the latched byte, not from tx_data_i.

## Timing
- Reset values:
  - tx_o=1, tx_ready_o=1, busy_o=0, done_o=0.
  - State=IDLE; all counters and the shift register are 0.
- Reset while a frame is in progress: outputs return to their reset values immediately (asynchronously). The frame is abandoned, and no done_o pulse is produced.
- Acceptance edge is cycle 0:
  - From cycle 1, tx_o=0, busy_o=1 and tx_ready_o=0.
  - The start bit occupies cycles 1..CLKS_PER_BIT.
- Frame length is F = (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT cycles, where P=1 if parity is compiled in, else 0.
- Cycle F+1 is the IDLE entry cycle:
  - busy_o=0, tx_ready_o=1, done_o=1.
- Back-to-back frames:
  - A byte held valid through cycle F+1 is accepted in that same cycle.
  - Its start bit begins at cycle F+2.
  - This inserts exactly one extra idle cycle (tx_o=1) between frames.
- There is no combinational path from tx_valid_i to tx_ready_o or to tx_o. All outputs are registered.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined:
  - The PARITY state and parity logic are present.
  - The parity bit is sent after the data bits; P=1.
- Undefined:
  - The PARITY state and parity logic are absent; PARITY_ODD is ignored.
  - DATA goes directly to STOP; P=0.

## Test plan
- Reset during a frame:
  - Stimulus: assert rst_ni low during the 4th data bit.
  - Required: tx_o=1, busy_o=0 and tx_ready_o=1 immediately; no done_o pulse.
  - After release, a byte 8'h3C transmits correctly.
- Basic frame, parity off:
  - Setup: CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1.
  - Stimulus: send 8'hA5.
  - Required: tx_o = 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop); each bit held 4 cycles.
  - Required: done_o high at cycle 41; total frame 40 cycles.
- Parity on, even:
  - Setup: UART_TX_PARITY_EN defined, PARITY_ODD=0.
  - Required: 8'hA5 gives parity bit 0; 8'hA4 gives parity bit 1.
  - Setup: PARITY_ODD=1.
  - Required: 8'hA5 gives parity bit 1.
- Back-to-back:
  - Stimulus: hold tx_valid_i high with bytes 8'h00 then 8'hFF.
  - Required: second start bit begins exactly one idle cycle after the first frame's stop bit ends.
  - Required: exactly 2 done_o pulses.
- Ignored input mid-frame:
  - Stimulus: toggle tx_valid_i and tx_data_i during a frame of 8'h55.
  - Required: serial output unchanged (1,0,1,0,1,0,1,0); tx_ready_o stays 0 until IDLE.
- Two stop bits:
  - Setup: STOP_BITS=2, CLKS_PER_BIT=3.
  - Required: tx_o high for 6 cycles after the last data bit before done_o.
